elevator_scheduler: RTL and testbench

// Car-level controller that owns the single access port of elevator_queue (FLOOR_COUNT-bit

---
 rtl/elevator_pkg.sv | 25 ++
 rtl/elevator_scan_select.sv | 42 ++++
 rtl/elevator_scheduler.sv | 159 +++++++++++++++
 tb/tb_elevator_scheduler.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared types and defaults for the elevator car controller.
// State and queue-port op encodings live here so every file agrees on them.
package elevator_pkg;

    localparam int DEF_FLOOR_COUNT = 8;
    localparam int DEF_FLOOR_W     = 3;
    localparam int DEF_DOOR_CYCLES = 16;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READ   = 3'd1,
        S_DECIDE = 3'd2,
        S_MOVE   = 3'd3,
        S_CLEAR  = 3'd4,
        S_DOOR   = 3'd5
    } state_e;

    // {r_nwr, clear_bit} pairs driven onto the queue port
    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_CLEAR = 2'b01,
        OP_READ  = 2'b10
    } qop_e;

endpackage

// File: rtl/elevator_scan_select.sv
// SCAN direction choice from a queue snapshot, the car floor and the current direction.
// Pure combinational; the masks keep the car inside floors 0..FLOOR_COUNT-1.
module elevator_scan_select
    import elevator_pkg::*;
#(
    parameter int FLOOR_COUNT = DEF_FLOOR_COUNT,
    parameter int FLOOR_W     = DEF_FLOOR_W
) (
    input  logic [FLOOR_COUNT-1:0] snap_i,
    input  logic [FLOOR_W-1:0]     floor_i,
    input  logic                   dir_up_i,
    output logic                   here_o,
    output logic                   go_up_o,
    output logic                   go_down_o,
    output logic                   next_dir_o
);

    logic [FLOOR_COUNT-1:0] above_mask;
    logic [FLOOR_COUNT-1:0] below_mask;
    logic                   above;
    logic                   below;

    always_comb begin
        above_mask = '0;
        below_mask = '0;
        for (int i = 0; i < FLOOR_COUNT; i++) begin
            above_mask[i] = FLOOR_W'(i) > floor_i;
            below_mask[i] = FLOOR_W'(i) < floor_i;
        end
    end

    assign here_o = snap_i[floor_i];
    assign above  = |(snap_i & above_mask);
    assign below  = |(snap_i & below_mask);

    // Keep going up while work lies above; only turn when nothing remains ahead
    assign go_up_o   = !here_o && above && (dir_up_i || !below);
    assign go_down_o = !here_o && below && !go_up_o;

    assign next_dir_o = go_up_o ? 1'b1 : (go_down_o ? 1'b0 : dir_up_i);

endmodule

// File: rtl/elevator_scheduler.sv
// Car-level controller: owns the floor queue port, runs SCAN, steps the car
// one floor per tick, clears served floors and times the door.
module elevator_scheduler
    import elevator_pkg::*;
#(
    parameter int FLOOR_COUNT = DEF_FLOOR_COUNT,
    parameter int FLOOR_W     = DEF_FLOOR_W,
    parameter int DOOR_CYCLES = DEF_DOOR_CYCLES
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [FLOOR_COUNT-1:0] call_req,
    input  logic [FLOOR_COUNT-1:0] q_rd_data,
    output logic                   q_r_nwr,
    output logic                   q_clear_bit,
    output logic [FLOOR_COUNT-1:0] q_wr_data,
    input  logic                   floor_tick,
    output logic                   motor_up,
    output logic                   motor_down,
    output logic                   door_open,
    output logic [FLOOR_W-1:0]     current_floor,
    output logic                   dir_up,
    output logic                   busy
);

    localparam int CNT_W = $clog2(DOOR_CYCLES + 1);

    state_e                 state_q, state_d;
    logic [FLOOR_W-1:0]     floor_q, floor_d;
    logic                   dir_q, dir_d;
    logic [FLOOR_COUNT-1:0] pending_q, pending_d;
    logic [FLOOR_COUNT-1:0] snap_q, snap_d;
    logic [CNT_W-1:0]       door_cnt_q, door_cnt_d;

    logic                   do_clear;
    logic                   do_write;
    logic                   do_read;
    qop_e                   op;
    logic [FLOOR_COUNT-1:0] clr_mask;

    logic here, go_up, go_down, next_dir;

    elevator_scan_select #(
        .FLOOR_COUNT(FLOOR_COUNT),
        .FLOOR_W    (FLOOR_W)
    ) u_scan (
        .snap_i    (snap_q),
        .floor_i   (floor_q),
        .dir_up_i  (dir_q),
        .here_o    (here),
        .go_up_o   (go_up),
        .go_down_o (go_down),
        .next_dir_o(next_dir)
    );

    // Port arbitration: clear beats a pending write, which beats a read
    assign do_clear = (state_q == S_CLEAR);
    assign do_write = !do_clear && (pending_q != '0);
    assign do_read  = !do_clear && !do_write;
    assign clr_mask = FLOOR_COUNT'(1) << floor_q;

    always_comb begin
        op        = OP_READ;
        q_wr_data = '0;
        if (do_clear) begin
            op        = OP_CLEAR;
            q_wr_data = clr_mask;
        end else if (do_write) begin
            op        = OP_WRITE;
            q_wr_data = pending_q;
        end
    end

    assign {q_r_nwr, q_clear_bit} = op;

    // A call landing in the write cycle survives into the next write
    assign pending_d = do_write ? call_req : (pending_q | call_req);

    always_comb begin
        state_d    = state_q;
        floor_d    = floor_q;
        dir_d      = dir_q;
        snap_d     = snap_q;
        door_cnt_d = door_cnt_q;
        motor_up   = 1'b0;
        motor_down = 1'b0;
        door_open  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (do_write) state_d = S_READ;
            end
            S_READ: begin
                if (do_read) begin
                    snap_d  = q_rd_data;
                    state_d = S_DECIDE;
                end
            end
            S_DECIDE: begin
                dir_d = next_dir;
                if (here) begin
                    state_d = S_CLEAR;
                end else if (go_up || go_down) begin
                    state_d = S_MOVE;
                end else if (do_write) begin
                    // a call written after the snapshot must not be stranded
                    state_d = S_READ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MOVE: begin
                motor_up   = dir_q;
                motor_down = !dir_q;
                if (floor_tick) begin
                    floor_d = dir_q ? floor_q + FLOOR_W'(1)
                                    : floor_q - FLOOR_W'(1);
                    state_d = S_READ;
                end
            end
            S_CLEAR: begin
                door_cnt_d = CNT_W'(DOOR_CYCLES);
                state_d    = S_DOOR;
            end
            S_DOOR: begin
                door_open = 1'b1;
                if (door_cnt_q <= CNT_W'(1)) begin
                    door_cnt_d = '0;
                    state_d    = S_READ;
                end else begin
                    door_cnt_d = door_cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            floor_q    <= '0;
            dir_q      <= 1'b1;
            pending_q  <= '0;
            snap_q     <= '0;
            door_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            floor_q    <= floor_d;
            dir_q      <= dir_d;
            pending_q  <= pending_d;
            snap_q     <= snap_d;
            door_cnt_q <= door_cnt_d;
        end
    end

    assign current_floor = floor_q;
    assign dir_up        = dir_q;
    assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_elevator_scheduler.sv
// Bench for elevator_scheduler: behavioural floor queue, floor_tick model,
// scoreboard of expected queue ops and door-open lengths.
module tb_elevator_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] call_req;
    logic [7:0] q_rd_data;
    logic       q_r_nwr;
    logic       q_clear_bit;
    logic [7:0] q_wr_data;
    logic       floor_tick;
    logic       motor_up;
    logic       motor_down;
    logic       door_open;
    logic [2:0] current_floor;
    logic       dir_up;
    logic       busy;

    logic [7:0] qmem;
    logic       model_tick = 1'b0;
    logic       force_tick = 1'b0;
    int         mcnt = 0;

    int checks = 0;
    int errors = 0;

    logic [8:0] op_q[$];
    int         door_q[$];
    int         door_len = 0;

    always #5 clk = ~clk;

    elevator_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .call_req     (call_req),
        .q_rd_data    (q_rd_data),
        .q_r_nwr      (q_r_nwr),
        .q_clear_bit  (q_clear_bit),
        .q_wr_data    (q_wr_data),
        .floor_tick   (floor_tick),
        .motor_up     (motor_up),
        .motor_down   (motor_down),
        .door_open    (door_open),
        .current_floor(current_floor),
        .dir_up       (dir_up),
        .busy         (busy)
    );

    // Queue: OR-in on write, AND-out on clear, contents always readable
    always @(posedge clk) begin
        if (reset) qmem <= 8'h00;
        else if (!q_r_nwr) qmem <= q_clear_bit ? (qmem & ~q_wr_data) : (qmem | q_wr_data);
    end
    assign q_rd_data  = q_r_nwr ? qmem : 8'h00;
    assign floor_tick = model_tick | force_tick;

    // Car reaches the next floor after the motor has run for 3 cycles
    always @(negedge clk) begin
        model_tick = 1'b0;
        if (motor_up || motor_down) begin
            mcnt++;
            if (mcnt == 3) begin
                model_tick = 1'b1;
                mcnt = 0;
            end
        end else begin
            mcnt = 0;
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(string name);
        checks++;
        errors++;
        $display("FAIL %s: wait expired at %0t", name, $time);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (reset) begin
            door_len = 0;
        end else begin
            chk("motor_excl", {31'd0, motor_up & motor_down}, 32'd0);
            if (!q_r_nwr) begin
                if (op_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL queue_op: unexpected op clr=%0b data=%0h", q_clear_bit, q_wr_data);
                end else begin
                    chk("queue_op", {23'd0, q_clear_bit, q_wr_data}, {23'd0, op_q.pop_front()});
                end
            end
            if (door_open) begin
                door_len++;
            end else if (door_len > 0) begin
                if (door_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL door_len: unexpected door of %0d cycles", door_len);
                end else begin
                    chk("door_len", door_len, door_q.pop_front());
                end
                door_len = 0;
            end
        end
    end

    task automatic wait_idle(int budget);
        int n;
        for (n = 0; n < budget; n++) begin
            @(negedge clk);
            if (!busy) break;
        end
        if (n == budget) timeout("wait_idle");
    endtask

    task automatic wait_door(int budget, output int n);
        for (n = 1; n <= budget; n++) begin
            @(negedge clk);
            if (door_open) break;
        end
        if (n > budget) timeout("wait_door");
    endtask

    task automatic wait_no_door(int budget);
        int n;
        for (n = 0; n < budget; n++) begin
            @(negedge clk);
            if (!door_open) break;
        end
        if (n == budget) timeout("wait_no_door");
    endtask

    task automatic wait_clear(logic [7:0] d, int budget);
        int n;
        for (n = 0; n < budget; n++) begin
            @(negedge clk);
            if (!q_r_nwr && q_clear_bit && q_wr_data == d) break;
        end
        if (n == budget) timeout("wait_clear");
    endtask

    task automatic pulse(logic [7:0] v);
        @(negedge clk);
        call_req = v;
        @(negedge clk);
        call_req = 8'h00;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap;
        reset    = 1'b1;
        call_req = 8'hFF;

        // Reset holds the port in read mode whatever the calls do
        repeat (3) begin
            @(negedge clk);
            chk("rst_r_nwr", q_r_nwr, 1);
            chk("rst_wr_data", q_wr_data, 0);
        end
        chk("rst_clear", q_clear_bit, 0);
        chk("rst_motors", {motor_up, motor_down}, 0);
        chk("rst_door", door_open, 0);
        chk("rst_busy", busy, 0);
        chk("rst_floor", current_floor, 0);
        chk("rst_dir", dir_up, 1);
        reset    = 1'b0;
        call_req = 8'h00;
        @(negedge clk);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_r_nwr", q_r_nwr, 1);

        // Single call to floor 3 with latency checks
        op_q.push_back({1'b0, 8'h08});
        op_q.push_back({1'b1, 8'h08});
        door_q.push_back(16);
        pulse(8'h08);
        chk("lat_write", q_wr_data, 8'h08);
        @(negedge clk);
        @(negedge clk);
        chk("lat_decide_motor", motor_up, 0);
        @(negedge clk);
        chk("lat_motor_up", motor_up, 1);
        wait_idle(400);
        chk("t2_floor", current_floor, 3);
        chk("t2_queue", qmem, 8'h00);

        // SCAN: floors 0 and 6 from floor 3 going up
        op_q.push_back({1'b0, 8'h41});
        op_q.push_back({1'b1, 8'h40});
        op_q.push_back({1'b1, 8'h01});
        door_q.push_back(16);
        door_q.push_back(16);
        pulse(8'h41);
        wait_door(200, gap);
        chk("t3_first_stop", current_floor, 6);
        chk("t3_dir_first", dir_up, 1);
        wait_idle(600);
        chk("t3_final_floor", current_floor, 0);
        chk("t3_dir_down", dir_up, 0);
        chk("t3_queue", qmem, 8'h00);

        // Re-call the current floor while the door is open
        op_q.push_back({1'b0, 8'h04});
        op_q.push_back({1'b1, 8'h04});
        op_q.push_back({1'b0, 8'h04});
        op_q.push_back({1'b1, 8'h04});
        door_q.push_back(16);
        door_q.push_back(16);
        pulse(8'h04);
        wait_door(200, gap);
        repeat (5) @(negedge clk);
        pulse(8'h04);
        wait_no_door(40);
        wait_door(20, gap);
        chk("t4_door_gap", gap, 3);
        chk("t4_floor", current_floor, 2);
        wait_idle(200);
        chk("t4_queue", qmem, 8'h00);

        // Calls colliding with a pending write and with a CLEAR
        op_q.push_back({1'b0, 8'h10});
        op_q.push_back({1'b0, 8'h20});
        op_q.push_back({1'b1, 8'h10});
        op_q.push_back({1'b0, 8'h80});
        op_q.push_back({1'b1, 8'h20});
        op_q.push_back({1'b1, 8'h80});
        door_q.push_back(16);
        door_q.push_back(16);
        door_q.push_back(16);
        @(negedge clk);
        call_req = 8'h10;
        @(negedge clk);
        call_req = 8'h20;
        chk("t5_write_a", q_wr_data, 8'h10);
        @(negedge clk);
        call_req = 8'h00;
        chk("t5_write_b", q_wr_data, 8'h20);
        @(negedge clk);
        chk("t5_queue_ab", qmem, 8'h30);
        wait_clear(8'h10, 200);
        call_req = 8'h80;
        @(negedge clk);
        call_req = 8'h00;
        @(negedge clk);
        chk("t5_clear_collide", qmem & 8'h80, 8'h80);
        wait_idle(600);
        chk("t5_floor", current_floor, 7);
        chk("t5_dir", dir_up, 1);
        chk("t5_queue", qmem, 8'h00);

        // Reset in the middle of a move, then a stray tick
        op_q.push_back({1'b0, 8'h01});
        pulse(8'h01);
        begin
            int n;
            for (n = 0; n < 20; n++) begin
                @(negedge clk);
                if (motor_down) break;
            end
            if (n == 20) timeout("wait_motor_down");
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t6_motors", {motor_up, motor_down}, 0);
        chk("t6_floor", current_floor, 0);
        chk("t6_busy", busy, 0);
        chk("t6_dir", dir_up, 1);
        force_tick = 1'b1;
        @(negedge clk);
        force_tick = 1'b0;
        chk("t6_tick_floor", current_floor, 0);
        chk("t6_tick_busy", busy, 0);
        repeat (3) @(negedge clk);
        chk("t6_motors_late", {motor_up, motor_down}, 0);

        chk("sb_ops_left", op_q.size(), 0);
        chk("sb_doors_left", door_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
